// File: rtl/cla_pkg.sv
// Shared constants and stage-register control fields for the pipelined CLA adder.
// Per-stage data widths depend on the stage index, so only the fixed-width fields live here.
package cla_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 8;

  // Control part of every stage register; resolved sum bits and unresolved
  // operand bits sit beside it with stage-dependent widths.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE_W-bit adder built from 4-bit lookahead groups whose
// group generate/propagate terms are chained across the slice.
module cla_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               carry_msb
);

  localparam int NGRP = SLICE_W / 4;

  logic [SLICE_W-1:0] p_s;
  logic [SLICE_W-1:0] g_s;
  logic [SLICE_W:0]   c_s;
  logic [NGRP-1:0]    gg_s;
  logic [NGRP-1:0]    gp_s;
  logic [NGRP:0]      cg_s;

  // Group lookahead, then per-bit carries expanded from each group carry-in.
  always_comb begin
    p_s  = a ^ b;
    g_s  = a & b;
    c_s  = '0;
    gg_s = '0;
    gp_s = '0;
    cg_s = '0;
    cg_s[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      gg_s[j] = g_s[4*j+3]
              | (p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
              | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      gp_s[j] = &p_s[4*j +: 4];
      cg_s[j+1] = gg_s[j] | (gp_s[j] & cg_s[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      c_s[4*j]   = cg_s[j];
      c_s[4*j+1] = g_s[4*j] | (p_s[4*j] & cg_s[j]);
      c_s[4*j+2] = g_s[4*j+1] | (p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+1] & p_s[4*j] & cg_s[j]);
      c_s[4*j+3] = g_s[4*j+2] | (p_s[4*j+2] & g_s[4*j+1])
                 | (p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & cg_s[j]);
    end
    c_s[SLICE_W] = cg_s[NGRP];
    sum       = p_s ^ c_s[SLICE_W-1:0];
    cout      = c_s[SLICE_W];
    carry_msb = c_s[SLICE_W-1];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Valid/ready pipelined adder/subtractor: each stage resolves one SLICE_W-bit
// slice with a CLA slice and passes the carry and remaining operand bits on.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / SLICE_W;

  if ((SLICE_W < 4) || ((SLICE_W % 4) != 0) || (WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of SLICE_W, SLICE_W a multiple of 4");
  end

  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [NSTAGE-1:0] valid_s;
  logic [NSTAGE:0]   load_s;

  assign b_eff_s   = sub ? ~b : b;
  assign cin_eff_s = sub ? 1'b1 : cin;

  // Backward load chain: a stage loads when empty or when its successor moves.
  always_comb begin
    load_s = '0;
    load_s[NSTAGE] = out_ready;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      load_s[k] = !valid_s[k] || load_s[k+1];
    end
  end

  assign in_ready = load_s[0];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SLICE_W;
    localparam int LO_W  = (k + 1) * SLICE_W;

    logic [SRC_W-1:0]   a_src_s;
    logic [SRC_W-1:0]   b_src_s;
    logic               c_src_s;
    logic               v_src_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_cout_s;
    logic               slice_cmsb_s;
    logic [LO_W-1:0]    sum_next_s;
    stage_ctl_t         ctl_r;
    logic [LO_W-1:0]    sum_r;

    if (k == 0) begin : g_src
      assign a_src_s    = a;
      assign b_src_s    = b_eff_s;
      assign c_src_s    = cin_eff_s;
      assign v_src_s    = in_valid;
      assign sum_next_s = slice_sum_s;
    end else begin : g_src
      assign a_src_s    = g_stage[k-1].g_hi.a_hi_r;
      assign b_src_s    = g_stage[k-1].g_hi.b_hi_r;
      assign c_src_s    = g_stage[k-1].ctl_r.carry;
      assign v_src_s    = g_stage[k-1].ctl_r.valid;
      assign sum_next_s = {slice_sum_s, g_stage[k-1].sum_r};
    end

    cla_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a         (a_src_s[SLICE_W-1:0]),
      .b         (b_src_s[SLICE_W-1:0]),
      .cin       (c_src_s),
      .sum       (slice_sum_s),
      .cout      (slice_cout_s),
      .carry_msb (slice_cmsb_s)
    );

    assign valid_s[k] = ctl_r.valid;

    // Stage register: valid, carry out and the low sum bits resolved so far.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_r <= '0;
        sum_r <= '0;
      end else if (load_s[k]) begin
        ctl_r.valid <= v_src_s;
        ctl_r.carry <= slice_cout_s;
        sum_r       <= sum_next_s;
      end
    end

    if (k < NSTAGE - 1) begin : g_hi
      logic [SRC_W-SLICE_W-1:0] a_hi_r;
      logic [SRC_W-SLICE_W-1:0] b_hi_r;
      logic                     unused_cmsb_s;

      assign unused_cmsb_s = slice_cmsb_s;

      // Operand bits not yet resolved travel with the transaction.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_r <= '0;
          b_hi_r <= '0;
        end else if (load_s[k]) begin
          a_hi_r <= a_src_s[SRC_W-1:SLICE_W];
          b_hi_r <= b_src_s[SRC_W-1:SLICE_W];
        end
      end
    end else begin : g_last
      logic ovf_r;

      // Signed overflow is the carry into the MSB disagreeing with the carry out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (load_s[k]) begin
          ovf_r <= slice_cout_s ^ slice_cmsb_s;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].ctl_r.valid;
  assign cout      = g_stage[NSTAGE-1].ctl_r.carry;
  assign sum       = g_stage[NSTAGE-1].sum_r;
  assign ovf       = g_stage[NSTAGE-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: scoreboard of arithmetic results plus a pipeline-occupancy
// model for in_ready, driven by directed cases and randomized traffic.
module tb_pipelined_cla_adder;

  localparam int W  = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  pipelined_cla_adder #(.WIDTH(W), .SLICE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [33:0]   exp_q[$];
  bit            stall_prev = 1'b0;
  logic [34:0]   held;
  bit            got_in;
  bit            got_out;
  bit            seen_ready;
  logic [33:0]   last_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic and sign-rule overflow, packed as {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
    logic [31:0] yy;
    logic [32:0] full;
    logic        v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : c)};
    v    = (x[31] == yy[31]) && (full[31] != x[31]);
    return {v, full};
  endfunction

  // One clock cycle, starting and ending on a falling edge.
  task automatic step(input bit iv, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input logic ts, input bit ordy);
    logic [33:0] e;
    in_valid  = iv;
    a         = ta;
    b         = tb;
    cin       = tc;
    sub       = ts;
    out_ready = ordy;
    #1;
    seen_ready = in_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, !((exp_q.size() == NS) && !ordy)});
    if (stall_prev) check("hold", {29'd0, out_valid, ovf, cout, sum}, {29'd0, held});
    got_in  = iv && in_ready;
    got_out = out_valid && ordy;
    if (got_out) begin
      last_res = {ovf, cout, sum};
      if (exp_q.size() == 0) begin
        check("extra_out", {30'd0, last_res}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {30'd0, last_res}, {30'd0, e});
      end
    end
    if (got_in) exp_q.push_back(ref_add(ta, tb, tc, ts));
    stall_prev = out_valid && !ordy;
    held       = {out_valid, ovf, cout, sum};
    @(negedge clk);
  endtask

  task automatic run_single(input logic [31:0] ta, input logic [31:0] tb,
                            input logic tc, input logic ts, output int lat);
    lat = -1;
    step(1'b1, ta, tb, tc, ts, 1'b1);
    check("single_accept", {63'd0, got_in}, 64'd1);
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      if (got_out) begin
        lat = j;
        break;
      end
    end
    check("latency", 64'(lat), 64'(NS));
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int sent;
    int pops;
    int last_pop;
    int ir_lo;
    int acc;
    int cyc;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #23;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_outputs", {30'd0, ovf, cout, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("wrap_value", {30'd0, last_res}, {30'd0, 1'b0, 1'b1, 32'h0000_0000});
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("ovf_value", {30'd0, last_res}, {30'd0, 1'b1, 1'b0, 32'h8000_0000});
    run_single(32'd5, 32'd7, 1'b1, 1'b1, lat);
    check("sub_value", {30'd0, last_res}, {30'd0, 1'b0, 1'b0, 32'hFFFF_FFFE});

    // Eight back-to-back inputs with the output stalled for cycles 6..8.
    sent = 0; pops = 0; last_pop = -1; ir_lo = 0;
    for (int c = 0; c < 20; c++) begin
      step(sent < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           !(c >= 6 && c <= 8));
      if (got_in) sent++;
      if (!seen_ready) ir_lo++;
      if (got_out) begin
        pops++;
        last_pop = c;
      end
    end
    check("stall_sent", 64'(sent), 64'd8);
    check("stall_pops", 64'(pops), 64'd8);
    check("stall_last_pop", 64'(last_pop), 64'd14);
    check("stall_inready_low", 64'(ir_lo), 64'd3);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_outputs", {30'd0, ovf, cout, sum}, 64'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_ghost", {63'd0, out_valid}, 64'd0);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    run_single(32'h1234_5678, 32'h0000_0FFF, 1'b1, 1'b0, lat);
    check("post_rst_value", {30'd0, last_res}, {30'd0, 1'b0, 1'b0, 32'h1234_6678});

    // Randomized traffic with random back-pressure.
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      step($urandom_range(0, 4) != 0, pick_op(), pick_op(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if (got_in) acc++;
      cyc++;
    end
    check("rand_accepted", 64'(acc), 64'd10000);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
